axi_mem_arbiter: RTL and testbench

//  Two-master AXI4 arbiter that shares the single DDR4 controller slave port (64-bit, 6-bit ID).
//  m0 is the Rocket io_mem_axi master; m1 is a second fabric master (debug loader or DMA).
//  AR and AW channels are arbitrated round-robin, one burst per grant.
//  The grant index is prepended as the slave ID MSB; R and B responses are routed back by that bit.

---
 rtl/axi_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: two-master AXI4 arbiter in front of a single DDR4 controller port.
// AR and AW are granted round-robin, one burst per grant; the grant index becomes the
// slave ID MSB and steers R/B responses back. Optional macro MEM_ARB_CALIB_GATE_EN adds
// a calib_done input that holds off new AR loads and new write grants until calibration.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
`ifdef MEM_ARB_CALIB_GATE_EN
    input  logic                  calib_done,
`endif
    // master 0 read address
    input  logic                  m0_ar_valid,
    output logic                  m0_ar_ready,
    input  logic [ADDR_W-1:0]     m0_ar_addr,
    input  logic [ID_W-1:0]       m0_ar_id,
    input  logic [7:0]            m0_ar_len,
    input  logic [2:0]            m0_ar_size,
    input  logic [1:0]            m0_ar_burst,
    // master 0 write address
    input  logic                  m0_aw_valid,
    output logic                  m0_aw_ready,
    input  logic [ADDR_W-1:0]     m0_aw_addr,
    input  logic [ID_W-1:0]       m0_aw_id,
    input  logic [7:0]            m0_aw_len,
    input  logic [2:0]            m0_aw_size,
    input  logic [1:0]            m0_aw_burst,
    // master 0 write data
    input  logic                  m0_w_valid,
    input  logic [DATA_W-1:0]     m0_w_data,
    input  logic [DATA_W/8-1:0]   m0_w_strb,
    input  logic                  m0_w_last,
    output logic                  m0_w_ready,
    // master 0 read data
    output logic                  m0_r_valid,
    output logic [DATA_W-1:0]     m0_r_data,
    output logic [ID_W-1:0]       m0_r_id,
    output logic [1:0]            m0_r_resp,
    output logic                  m0_r_last,
    input  logic                  m0_r_ready,
    // master 0 write response
    output logic                  m0_b_valid,
    output logic [ID_W-1:0]       m0_b_id,
    output logic [1:0]            m0_b_resp,
    input  logic                  m0_b_ready,
    // master 1 read address
    input  logic                  m1_ar_valid,
    output logic                  m1_ar_ready,
    input  logic [ADDR_W-1:0]     m1_ar_addr,
    input  logic [ID_W-1:0]       m1_ar_id,
    input  logic [7:0]            m1_ar_len,
    input  logic [2:0]            m1_ar_size,
    input  logic [1:0]            m1_ar_burst,
    // master 1 write address
    input  logic                  m1_aw_valid,
    output logic                  m1_aw_ready,
    input  logic [ADDR_W-1:0]     m1_aw_addr,
    input  logic [ID_W-1:0]       m1_aw_id,
    input  logic [7:0]            m1_aw_len,
    input  logic [2:0]            m1_aw_size,
    input  logic [1:0]            m1_aw_burst,
    // master 1 write data
    input  logic                  m1_w_valid,
    input  logic [DATA_W-1:0]     m1_w_data,
    input  logic [DATA_W/8-1:0]   m1_w_strb,
    input  logic                  m1_w_last,
    output logic                  m1_w_ready,
    // master 1 read data
    output logic                  m1_r_valid,
    output logic [DATA_W-1:0]     m1_r_data,
    output logic [ID_W-1:0]       m1_r_id,
    output logic [1:0]            m1_r_resp,
    output logic                  m1_r_last,
    input  logic                  m1_r_ready,
    // master 1 write response
    output logic                  m1_b_valid,
    output logic [ID_W-1:0]       m1_b_id,
    output logic [1:0]            m1_b_resp,
    input  logic                  m1_b_ready,
    // slave read address
    output logic                  s_ar_valid,
    input  logic                  s_ar_ready,
    output logic [ADDR_W-1:0]     s_ar_addr,
    output logic [ID_W:0]         s_ar_id,
    output logic [7:0]            s_ar_len,
    output logic [2:0]            s_ar_size,
    output logic [1:0]            s_ar_burst,
    // slave write address
    output logic                  s_aw_valid,
    input  logic                  s_aw_ready,
    output logic [ADDR_W-1:0]     s_aw_addr,
    output logic [ID_W:0]         s_aw_id,
    output logic [7:0]            s_aw_len,
    output logic [2:0]            s_aw_size,
    output logic [1:0]            s_aw_burst,
    // slave write data
    output logic                  s_w_valid,
    output logic [DATA_W-1:0]     s_w_data,
    output logic [DATA_W/8-1:0]   s_w_strb,
    output logic                  s_w_last,
    input  logic                  s_w_ready,
    // slave read data
    input  logic                  s_r_valid,
    input  logic [DATA_W-1:0]     s_r_data,
    input  logic [ID_W:0]         s_r_id,
    input  logic [1:0]            s_r_resp,
    input  logic                  s_r_last,
    output logic                  s_r_ready,
    // slave write response
    input  logic                  s_b_valid,
    input  logic [ID_W:0]         s_b_id,
    input  logic [1:0]            s_b_resp,
    output logic                  s_b_ready
);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } w_state_t;

    logic     grant_en;

    // read address arbitration
    logic     ar_last_q;   // index of the master granted most recently
    logic     ar_sel;
    logic     ar_load;

    // write path
    w_state_t state_q;
    w_state_t state_d;
    logic     owner_q;
    logic     aw_last_q;
    logic     aw_sel;
    logic     aw_grant;
    logic     aw_done_q;
    logic     w_done_q;
    logic     aw_fire;
    logic     w_last_fire;
    logic     w_pass;

`ifdef MEM_ARB_CALIB_GATE_EN
    assign grant_en = calib_done;
`else
    assign grant_en = 1'b1;
`endif

    // AR round-robin pick; the slice accepts a new request when empty or draining this cycle
    always_comb begin
        if (m0_ar_valid && m1_ar_valid) begin
            ar_sel = ~ar_last_q;
        end else begin
            ar_sel = m1_ar_valid;
        end
        ar_load     = reset_n && grant_en && (m0_ar_valid || m1_ar_valid)
                      && (!s_ar_valid || s_ar_ready);
        m0_ar_ready = ar_load && !ar_sel;
        m1_ar_ready = ar_load && ar_sel;
    end

    // AR slice occupancy and RR pointer; reset points at m1 so m0 wins the first tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_ar_valid <= 1'b0;
            ar_last_q  <= 1'b1;
        end else if (ar_load) begin
            s_ar_valid <= 1'b1;
            ar_last_q  <= ar_sel;
        end else if (s_ar_ready) begin
            s_ar_valid <= 1'b0;
        end
    end

    // AR slice payload; qualified by s_ar_valid so it needs no reset
    always_ff @(posedge clock) begin
        if (ar_load) begin
            s_ar_addr  <= ar_sel ? m1_ar_addr  : m0_ar_addr;
            s_ar_id    <= ar_sel ? {1'b1, m1_ar_id} : {1'b0, m0_ar_id};
            s_ar_len   <= ar_sel ? m1_ar_len   : m0_ar_len;
            s_ar_size  <= ar_sel ? m1_ar_size  : m0_ar_size;
            s_ar_burst <= ar_sel ? m1_ar_burst : m0_ar_burst;
        end
    end

    // AW round-robin pick; a grant is only possible from IDLE so W order follows AW order
    always_comb begin
        if (m0_aw_valid && m1_aw_valid) begin
            aw_sel = ~aw_last_q;
        end else begin
            aw_sel = m1_aw_valid;
        end
        aw_grant    = reset_n && grant_en && (state_q == W_IDLE)
                      && (m0_aw_valid || m1_aw_valid);
        aw_fire     = s_aw_valid && s_aw_ready;
        w_last_fire = s_w_valid && s_w_ready && s_w_last;
    end

    // write FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // write FSM next state: BUSY ends once both the AW and the last W beat have gone out
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE: begin
                if (aw_grant) begin
                    state_d = W_BUSY;
                end
            end
            W_BUSY: begin
                if ((aw_done_q || aw_fire) && (w_done_q || w_last_fire)) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // write FSM outputs: AW ready pulse in IDLE, owner-only W pass-through in BUSY
    always_comb begin
        w_pass      = (state_q == W_BUSY) && !w_done_q;
        m0_aw_ready = aw_grant && !aw_sel;
        m1_aw_ready = aw_grant && aw_sel;
        s_w_valid   = w_pass && (owner_q ? m1_w_valid : m0_w_valid);
        s_w_data    = owner_q ? m1_w_data : m0_w_data;
        s_w_strb    = owner_q ? m1_w_strb : m0_w_strb;
        s_w_last    = owner_q ? m1_w_last : m0_w_last;
        m0_w_ready  = w_pass && !owner_q && s_w_ready;
        m1_w_ready  = w_pass && owner_q && s_w_ready;
    end

    // AW slice occupancy, burst owner, RR pointer and the two completion flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_aw_valid <= 1'b0;
            owner_q    <= 1'b0;
            aw_last_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else if (aw_grant) begin
            s_aw_valid <= 1'b1;
            owner_q    <= aw_sel;
            aw_last_q  <= aw_sel;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else if (state_q == W_BUSY) begin
            if (aw_fire) begin
                s_aw_valid <= 1'b0;
                aw_done_q  <= 1'b1;
            end
            if (w_last_fire) begin
                w_done_q <= 1'b1;
            end
            if (state_d == W_IDLE) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

    // AW slice payload; qualified by s_aw_valid so it needs no reset
    always_ff @(posedge clock) begin
        if (aw_grant) begin
            s_aw_addr  <= aw_sel ? m1_aw_addr  : m0_aw_addr;
            s_aw_id    <= aw_sel ? {1'b1, m1_aw_id} : {1'b0, m0_aw_id};
            s_aw_len   <= aw_sel ? m1_aw_len   : m0_aw_len;
            s_aw_size  <= aw_sel ? m1_aw_size  : m0_aw_size;
            s_aw_burst <= aw_sel ? m1_aw_burst : m0_aw_burst;
        end
    end

    // R and B responses steered back by the ID MSB; payload is broadcast, valid is not
    always_comb begin
        m0_r_valid = reset_n && s_r_valid && !s_r_id[ID_W];
        m1_r_valid = reset_n && s_r_valid && s_r_id[ID_W];
        m0_r_data  = s_r_data;
        m1_r_data  = s_r_data;
        m0_r_id    = s_r_id[ID_W-1:0];
        m1_r_id    = s_r_id[ID_W-1:0];
        m0_r_resp  = s_r_resp;
        m1_r_resp  = s_r_resp;
        m0_r_last  = s_r_last;
        m1_r_last  = s_r_last;
        s_r_ready  = reset_n && (s_r_id[ID_W] ? m1_r_ready : m0_r_ready);
        m0_b_valid = reset_n && s_b_valid && !s_b_id[ID_W];
        m1_b_valid = reset_n && s_b_valid && s_b_id[ID_W];
        m0_b_id    = s_b_id[ID_W-1:0];
        m1_b_id    = s_b_id[ID_W-1:0];
        m0_b_resp  = s_b_resp;
        m1_b_resp  = s_b_resp;
        s_b_ready  = reset_n && (s_b_id[ID_W] ? m1_b_ready : m0_b_ready);
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed and randomized bench for axi_mem_arbiter (ADDR_W=32, DATA_W=64, ID_W=5).
module tb_axi_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
`ifdef MEM_ARB_CALIB_GATE_EN
    logic        calib_done;
`endif
    logic        m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
    logic [31:0] m0_ar_addr, m1_ar_addr;
    logic [4:0]  m0_ar_id, m1_ar_id;
    logic [7:0]  m0_ar_len, m1_ar_len;
    logic [2:0]  m0_ar_size, m1_ar_size;
    logic [1:0]  m0_ar_burst, m1_ar_burst;
    logic        m0_aw_valid, m0_aw_ready, m1_aw_valid, m1_aw_ready;
    logic [31:0] m0_aw_addr, m1_aw_addr;
    logic [4:0]  m0_aw_id, m1_aw_id;
    logic [7:0]  m0_aw_len, m1_aw_len;
    logic [2:0]  m0_aw_size, m1_aw_size;
    logic [1:0]  m0_aw_burst, m1_aw_burst;
    logic        m0_w_valid, m0_w_last, m0_w_ready, m1_w_valid, m1_w_last, m1_w_ready;
    logic [63:0] m0_w_data, m1_w_data;
    logic [7:0]  m0_w_strb, m1_w_strb;
    logic        m0_r_valid, m0_r_last, m0_r_ready, m1_r_valid, m1_r_last, m1_r_ready;
    logic [63:0] m0_r_data, m1_r_data;
    logic [4:0]  m0_r_id, m1_r_id, m0_b_id, m1_b_id;
    logic [1:0]  m0_r_resp, m1_r_resp, m0_b_resp, m1_b_resp;
    logic        m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
    logic        s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready;
    logic [31:0] s_ar_addr, s_aw_addr;
    logic [5:0]  s_ar_id, s_aw_id, s_r_id, s_b_id;
    logic [7:0]  s_ar_len, s_aw_len;
    logic [2:0]  s_ar_size, s_aw_size;
    logic [1:0]  s_ar_burst, s_aw_burst;
    logic        s_w_valid, s_w_last, s_w_ready;
    logic [63:0] s_w_data, s_r_data;
    logic [7:0]  s_w_strb;
    logic        s_r_valid, s_r_last, s_r_ready, s_b_valid, s_b_ready;
    logic [1:0]  s_r_resp, s_b_resp;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [4:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    always #5 clock = ~clock;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(5)) dut (
        .clock(clock), .reset_n(reset_n),
`ifdef MEM_ARB_CALIB_GATE_EN
        .calib_done(calib_done),
`endif
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_ar_id(m0_ar_id), .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_addr(m0_aw_addr),
        .m0_aw_id(m0_aw_id), .m0_aw_len(m0_aw_len), .m0_aw_size(m0_aw_size), .m0_aw_burst(m0_aw_burst),
        .m0_w_valid(m0_w_valid), .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_last(m0_w_last),
        .m0_w_ready(m0_w_ready),
        .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_id(m0_r_id), .m0_r_resp(m0_r_resp),
        .m0_r_last(m0_r_last), .m0_r_ready(m0_r_ready),
        .m0_b_valid(m0_b_valid), .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp), .m0_b_ready(m0_b_ready),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_ar_id(m1_ar_id), .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr),
        .m1_aw_id(m1_aw_id), .m1_aw_len(m1_aw_len), .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst),
        .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
        .m1_w_ready(m1_w_ready),
        .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_id(m1_r_id), .m1_r_resp(m1_r_resp),
        .m1_r_last(m1_r_last), .m1_r_ready(m1_r_ready),
        .m1_b_valid(m1_b_valid), .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_ready(s_w_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_id(s_r_id), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .s_b_valid(s_b_valid), .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        {m0_ar_valid, m1_ar_valid, m0_aw_valid, m1_aw_valid} = '0;
        {m0_w_valid, m1_w_valid, m0_w_last, m1_w_last} = '0;
        {m0_r_ready, m1_r_ready, m0_b_ready, m1_b_ready} = '0;
        {s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_r_last, s_b_valid} = '0;
        {m0_ar_addr, m1_ar_addr, m0_aw_addr, m1_aw_addr} = '0;
        {m0_ar_id, m1_ar_id, m0_aw_id, m1_aw_id} = '0;
        {m0_ar_len, m1_ar_len, m0_aw_len, m1_aw_len} = '0;
        {m0_ar_size, m1_ar_size, m0_aw_size, m1_aw_size} = '0;
        {m0_ar_burst, m1_ar_burst, m0_aw_burst, m1_aw_burst} = '0;
        {m0_w_data, m1_w_data, s_r_data} = '0;
        {m0_w_strb, m1_w_strb} = '0;
        {s_r_id, s_b_id, s_r_resp, s_b_resp} = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.v     = 1'b1;
        r.addr  = $urandom;
        r.id    = 5'($urandom);
        r.len   = 8'($urandom);
        r.size  = 3'($urandom);
        r.burst = 2'($urandom);
        return r;
    endfunction

    req_t        pend [2];
    req_t        slot;
    logic [5:0]  slot_id;
    int          last_g;
    int          win;
    logic        can_load, load;
    logic [63:0] rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_ARB_CALIB_GATE_EN
        calib_done = 1'b1;
`endif
        reset_n = 1'b0;
        clear_inputs();
        // reset state with requests and responses presented
        m0_ar_valid = 1'b1; m1_aw_valid = 1'b1; s_r_valid = 1'b1; s_b_valid = 1'b1;
        m0_r_ready = 1'b1; m0_b_ready = 1'b1;
        repeat (2) tick();
        chk("rst_s_ar_valid", s_ar_valid, 0);
        chk("rst_s_aw_valid", s_aw_valid, 0);
        chk("rst_s_w_valid", s_w_valid, 0);
        chk("rst_m0_ar_ready", m0_ar_ready, 0);
        chk("rst_m1_aw_ready", m1_aw_ready, 0);
        chk("rst_m0_r_valid", m0_r_valid, 0);
        chk("rst_m0_b_valid", m0_b_valid, 0);
        chk("rst_s_r_ready", s_r_ready, 0);
        do_reset();

        // single m0 read burst
        m0_ar_valid = 1'b1; m0_ar_addr = 32'h1000_0000; m0_ar_id = 5'd3; m0_ar_len = 8'd7;
        m0_ar_size = 3'd3; m0_ar_burst = 2'd1; s_ar_ready = 1'b1;
        settle();
        chk("ar1_m0_ready", m0_ar_ready, 1);
        chk("ar1_m1_ready", m1_ar_ready, 0);
        chk("ar1_s_valid_before", s_ar_valid, 0);
        tick();
        m0_ar_valid = 1'b0;
        settle();
        chk("ar1_s_valid", s_ar_valid, 1);
        chk("ar1_s_id", s_ar_id, 6'h03);
        chk("ar1_s_addr", s_ar_addr, 32'h1000_0000);
        chk("ar1_s_len", s_ar_len, 7);
        chk("ar1_s_burst", s_ar_burst, 1);
        tick();
        chk("ar1_s_drain", s_ar_valid, 0);
        m0_r_ready = 1'b1; m1_r_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            rd = {$urandom, $urandom};
            s_r_valid = 1'b1; s_r_id = 6'h03; s_r_data = rd; s_r_last = (b == 7); s_r_resp = 2'b00;
            settle();
            chk("r1_m0_valid", m0_r_valid, 1);
            chk("r1_m1_valid", m1_r_valid, 0);
            chk("r1_m0_id", m0_r_id, 3);
            chk("r1_m0_data", m0_r_data, rd);
            chk("r1_m0_last", m0_r_last, (b == 7));
            chk("r1_s_ready", s_r_ready, 1);
            tick();
        end
        clear_inputs();

        // simultaneous AR requests alternate from reset
        do_reset();
        s_ar_ready = 1'b1;
        m0_ar_valid = 1'b1; m0_ar_id = 5'd1;
        m1_ar_valid = 1'b1; m1_ar_id = 5'd2;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_m0_ready", m0_ar_ready, (k % 2 == 0));
            chk("rr_m1_ready", m1_ar_ready, (k % 2 == 1));
            tick();
            chk("rr_s_valid", s_ar_valid, 1);
            chk("rr_s_id_msb", s_ar_id[5], (k % 2 == 1));
        end
        clear_inputs();

        // m1 write with W ahead of a stalled AW; m0 AW waits
        do_reset();
        s_w_ready = 1'b1;
        m1_aw_valid = 1'b1; m1_aw_id = 5'h0A; m1_aw_addr = 32'h2000_0040; m1_aw_len = 8'd3;
        m1_w_valid = 1'b1; m1_w_data = 64'hA0; m1_w_strb = 8'hFF;
        settle();
        chk("w_m1_aw_ready", m1_aw_ready, 1);
        chk("w_m0_aw_ready_idle", m0_aw_ready, 0);
        chk("w_idle_no_pass", s_w_valid, 0);
        chk("w_idle_m1_w_ready", m1_w_ready, 0);
        tick();
        m1_aw_valid = 1'b0;
        m0_aw_valid = 1'b1; m0_aw_id = 5'h02; m0_aw_len = 8'd0; m0_aw_addr = 32'h3000_0000;
        m0_w_valid = 1'b1; m0_w_data = 64'hBEEF; m0_w_last = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m1_w_data = 64'hA0 + 64'(b); m1_w_last = (b == 3);
            settle();
            chk("w_beat_valid", s_w_valid, 1);
            chk("w_beat_data", s_w_data, 64'hA0 + 64'(b));
            chk("w_beat_last", s_w_last, (b == 3));
            chk("w_m1_w_ready", m1_w_ready, 1);
            chk("w_m0_w_ready", m0_w_ready, 0);
            chk("w_m0_aw_wait", m0_aw_ready, 0);
            chk("w_s_aw_held", s_aw_valid, 1);
            chk("w_s_aw_id", s_aw_id, 6'h2A);
            tick();
        end
        m1_w_valid = 1'b0; m1_w_last = 1'b0;
        settle();
        chk("w_after_last", s_w_valid, 0);
        chk("w_busy_m0_aw", m0_aw_ready, 0);
        tick();
        s_aw_ready = 1'b1;
        settle();
        chk("w_aw_fire_valid", s_aw_valid, 1);
        chk("w_aw_fire_m0_aw", m0_aw_ready, 0);
        tick();
        s_aw_ready = 1'b0;
        settle();
        chk("w_idle_m0_aw", m0_aw_ready, 1);
        tick();
        m0_aw_valid = 1'b0;
        settle();
        chk("w_m0_s_aw_id", s_aw_id, 6'h02);
        // AW and the single W beat complete in the same cycle
        s_aw_ready = 1'b1;
        settle();
        chk("w_m0_pass", s_w_valid, 1);
        chk("w_m0_w_ready_busy", m0_w_ready, 1);
        chk("w_m0_data", s_w_data, 64'hBEEF);
        tick();
        m0_w_valid = 1'b0; s_aw_ready = 1'b0;
        m1_aw_valid = 1'b1; m1_aw_id = 5'h05; m1_aw_len = 8'd3;
        settle();
        chk("w_same_cycle_idle", m1_aw_ready, 1);
        tick();
        m1_aw_valid = 1'b0;

        // reset during W beat 2 of 4
        m1_w_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m1_w_data = 64'(b); m1_w_last = 1'b0;
            tick();
        end
        m1_w_data = 64'd2; m0_ar_valid = 1'b1; m0_aw_valid = 1'b1;
        s_r_valid = 1'b1; s_r_id = 6'h01; m0_r_ready = 1'b1; s_b_valid = 1'b1; s_b_id = 6'h21;
        settle();
        chk("mid_beat2_pass", s_w_valid, 1);
        reset_n = 1'b0;
        settle();
        chk("mid_rst_s_w_valid", s_w_valid, 0);
        chk("mid_rst_m1_w_ready", m1_w_ready, 0);
        chk("mid_rst_s_aw_valid", s_aw_valid, 0);
        chk("mid_rst_s_ar_valid", s_ar_valid, 0);
        chk("mid_rst_m0_ar_ready", m0_ar_ready, 0);
        chk("mid_rst_m0_aw_ready", m0_aw_ready, 0);
        chk("mid_rst_m0_r_valid", m0_r_valid, 0);
        chk("mid_rst_m1_b_valid", m1_b_valid, 0);
        clear_inputs();
        tick();
        reset_n = 1'b1;
        m0_aw_valid = 1'b1; m1_aw_valid = 1'b1;
        settle();
        chk("post_rst_m0_first", m0_aw_ready, 1);
        chk("post_rst_m1_wait", m1_aw_ready, 0);
        do_reset();

        // B responses routed by ID MSB
        s_b_valid = 1'b1; s_b_id = 6'h21; s_b_resp = 2'b00; m1_b_ready = 1'b1; m0_b_ready = 1'b0;
        settle();
        chk("b1_m1_valid", m1_b_valid, 1);
        chk("b1_m1_id", m1_b_id, 1);
        chk("b1_m0_valid", m0_b_valid, 0);
        chk("b1_s_ready", s_b_ready, 1);
        tick();
        s_b_id = 6'h04; s_b_resp = 2'b10; m1_b_ready = 1'b1; m0_b_ready = 1'b0;
        settle();
        chk("b2_m0_valid", m0_b_valid, 1);
        chk("b2_m0_id", m0_b_id, 4);
        chk("b2_m0_resp", m0_b_resp, 2);
        chk("b2_m1_valid", m1_b_valid, 0);
        chk("b2_s_ready_low", s_b_ready, 0);
        m0_b_ready = 1'b1;
        settle();
        chk("b2_s_ready", s_b_ready, 1);
        tick();
        clear_inputs();

`ifdef MEM_ARB_CALIB_GATE_EN
        // grants held off until calibration completes
        do_reset();
        calib_done = 1'b0;
        m0_ar_valid = 1'b1; m0_ar_id = 5'd7; s_ar_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            settle();
            chk("cal_s_ar_valid", s_ar_valid, 0);
            chk("cal_m0_ar_ready", m0_ar_ready, 0);
            tick();
        end
        calib_done = 1'b1;
        settle();
        chk("cal_ready_rise", m0_ar_ready, 1);
        tick();
        chk("cal_s_ar_valid_rise", s_ar_valid, 1);
        chk("cal_s_ar_id", s_ar_id, 6'h07);
        clear_inputs();
`endif

        // randomized AR traffic and R routing against a transaction-level model
        do_reset();
        pend[0].v = 1'b0; pend[1].v = 1'b0; slot.v = 1'b0; slot_id = '0; last_g = 1;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m].v && $urandom_range(0, 2) != 0) pend[m] = rand_req();
            end
            m0_ar_valid = pend[0].v; m0_ar_addr = pend[0].addr; m0_ar_id = pend[0].id;
            m0_ar_len = pend[0].len; m0_ar_size = pend[0].size; m0_ar_burst = pend[0].burst;
            m1_ar_valid = pend[1].v; m1_ar_addr = pend[1].addr; m1_ar_id = pend[1].id;
            m1_ar_len = pend[1].len; m1_ar_size = pend[1].size; m1_ar_burst = pend[1].burst;
            s_ar_ready = ($urandom_range(0, 3) != 0);
            s_r_valid = 1'($urandom); s_r_id = 6'($urandom); s_r_data = {$urandom, $urandom};
            m0_r_ready = 1'($urandom); m1_r_ready = 1'($urandom);
            settle();
            can_load = !slot.v || s_ar_ready;
            if (pend[0].v && pend[1].v) win = (last_g == 0) ? 1 : 0;
            else win = pend[1].v ? 1 : 0;
            load = can_load && (pend[0].v || pend[1].v);
            chk("rnd_m0_ar_ready", m0_ar_ready, load && (win == 0));
            chk("rnd_m1_ar_ready", m1_ar_ready, load && (win == 1));
            chk("rnd_s_ar_valid", s_ar_valid, slot.v);
            if (slot.v) begin
                chk("rnd_s_ar_id", s_ar_id, slot_id);
                chk("rnd_s_ar_addr", s_ar_addr, slot.addr);
                chk("rnd_s_ar_len", s_ar_len, slot.len);
                chk("rnd_s_ar_size", s_ar_size, slot.size);
                chk("rnd_s_ar_burst", s_ar_burst, slot.burst);
            end
            chk("rnd_m0_r_valid", m0_r_valid, s_r_valid && (s_r_id < 6'd32));
            chk("rnd_m1_r_valid", m1_r_valid, s_r_valid && (s_r_id >= 6'd32));
            chk("rnd_r_id", m1_r_id, s_r_id % 32);
            chk("rnd_s_r_ready", s_r_ready, (s_r_id >= 6'd32) ? m1_r_ready : m0_r_ready);
            if (load) begin
                slot = pend[win];
                slot_id = 6'(win * 32) + 6'(pend[win].id);
                pend[win].v = 1'b0;
                last_g = win;
            end else if (s_ar_ready) begin
                slot.v = 1'b0;
            end
            tick();
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
